imem_loader: RTL and testbench

Instruction-side counterpart of the MIPS core's fetch interface. It accepts a program as a valid/ready word stream from a host or bench, stores it, then serves `instr` combinationally from the core's `pc`. While a program is loading, it holds the core in reset. It sits between the program source and `mips_core` in the top level, next to `data_mem`.

---
 rtl/mips_pkg.sv | 11 +
 rtl/imem_loader.sv | 129 ++++++++++++
 tb/tb_imem_loader.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core types and sizes; this slice adds the instruction-memory
// loader state type and default depth.
package mips_pkg;

    localparam int PC_WIDTH     = 32;
    localparam int INSTR_WITDTH = 32;
    localparam int IMEM_DEPTH   = 256;

    typedef enum logic {LOAD, RUN} imem_state_e;

endpackage

// File: rtl/imem_loader.sv
// Instruction memory fed by a valid/ready program stream; holds the core in reset while loading.
// Optional fetch bounds checking: define IMEM_BOUNDS_CHECK_EN.
module imem_loader
    import mips_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [INSTR_WITDTH-1:0] load_data,
    input  logic                    load_last,
    input  logic                    reload,
    input  logic [PC_WIDTH-1:0]     pc,
    output logic [INSTR_WITDTH-1:0] instr,
    output logic                    core_rst_n,
    output logic [AW:0]             prog_len,
    output logic                    load_ovf,
    output logic                    fetch_err
);

    imem_state_e             state_q;
    imem_state_e             state_d;
    logic [AW-1:0]           wr_ptr;
    logic [INSTR_WITDTH-1:0] mem [DEPTH];
    logic                    hs;
    logic                    at_end;
    logic                    run_reload;
    logic [AW-1:0]           rd_idx;

    assign at_end     = (wr_ptr == AW'(DEPTH - 1));
    assign run_reload = (state_q == RUN) && reload;
    assign rd_idx     = pc[AW+1:2];
    assign core_rst_n = (state_q == RUN);

    always_comb begin
        state_d    = state_q;
        load_ready = 1'b0;
        hs         = 1'b0;
        case (state_q)
            LOAD: begin
                load_ready = !reload;
                hs         = load_valid && !reload;
                if (hs && (load_last || at_end))
                    state_d = RUN;
            end
            RUN: begin
                if (reload)
                    state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= LOAD;
        else
            state_q <= state_d;
    end

    // A final word landing exactly on the last slot is a normal end, not an overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            prog_len <= '0;
            load_ovf <= 1'b0;
        end else begin
            if (reload)
                wr_ptr <= '0;
            else if (hs)
                wr_ptr <= wr_ptr + AW'(1);

            if (hs && load_last) begin
                prog_len <= {1'b0, wr_ptr} + (AW+1)'(1);
            end else if (hs && at_end) begin
                prog_len <= (AW+1)'(DEPTH);
                load_ovf <= 1'b1;
            end else if (run_reload) begin
                prog_len <= '0;
                load_ovf <= 1'b0;
            end
        end
    end

    // Program storage: synchronous write, asynchronous read, never reset.
    always_ff @(posedge clk) begin
        if (hs)
            mem[wr_ptr] <= load_data;
    end

`ifdef IMEM_BOUNDS_CHECK_EN
    logic fetch_bad;

    assign fetch_bad = (pc[1:0] != 2'b00)
                    || ((pc >> (AW + 2)) != '0)
                    || ({1'b0, rd_idx} >= prog_len);

    always_comb begin
        instr = '0;
        if (state_q == RUN && !fetch_bad)
            instr = mem[rd_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fetch_err <= 1'b0;
        else if (run_reload)
            fetch_err <= 1'b0;
        else if (state_q == RUN && fetch_bad)
            fetch_err <= 1'b1;
    end
`else
    // Index wraps modulo DEPTH; alignment and upper address bits are don't-care.
    logic unused_pc_bits;

    assign unused_pc_bits = ^{pc[PC_WIDTH-1:AW+2], pc[1:0]};
    assign fetch_err      = 1'b0;

    always_comb begin
        instr = '0;
        if (state_q == RUN)
            instr = mem[rd_idx];
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader (DEPTH = 4): a program-level reference model
// predicts every probed cycle and a negedge monitor compares the DUT against it.
module tb_imem_loader;
    import mips_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic                    clk;
    logic                    rst_n;
    logic                    load_valid;
    logic                    load_ready;
    logic [INSTR_WITDTH-1:0] load_data;
    logic                    load_last;
    logic                    reload;
    logic [PC_WIDTH-1:0]     pc;
    logic [INSTR_WITDTH-1:0] instr;
    logic                    core_rst_n;
    logic [AW:0]             prog_len;
    logic                    load_ovf;
    logic                    fetch_err;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data (load_data),
        .load_last (load_last),
        .reload    (reload),
        .pc        (pc),
        .instr     (instr),
        .core_rst_n(core_rst_n),
        .prog_len  (prog_len),
        .load_ovf  (load_ovf),
        .fetch_err (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] instr;
        logic        crn;
        logic        rdy;
        logic [31:0] plen;
        logic        ovf;
        logic        ferr;
    } exp_t;

    exp_t expq[$];
    bit   probe;
    int   checks;
    int   errors;

    // Reference model: program image plus load/run bookkeeping.
    logic [31:0] m_mem [DEPTH];
    bit          written [DEPTH];
    bit          m_run;
    int unsigned m_wptr;
    int unsigned m_len;
    bit          m_ovf;
    bit          m_ferr;

    function automatic bit bad_fetch(input logic [31:0] p);
`ifdef IMEM_BOUNDS_CHECK_EN
        return (p[1:0] != 2'b00) || ((p >> 2) >= m_len);
`else
        return 1'b0;
`endif
    endfunction

    function automatic exp_t predict(input string tag, input logic rl, input logic [31:0] p);
        exp_t e;
        e.tag   = tag;
        e.crn   = m_run;
        e.rdy   = !m_run && !rl;
        e.plen  = m_len;
        e.ovf   = m_ovf;
        e.ferr  = m_ferr;
        e.instr = (m_run && !bad_fetch(p)) ? m_mem[(p >> 2) % DEPTH] : 32'h0;
        return e;
    endfunction

    task automatic model_step(input logic v, input logic [31:0] d, input logic l,
                              input logic rl, input logic [31:0] p);
        if (!m_run) begin
            if (rl) begin
                m_wptr = 0;
            end else if (v) begin
                m_mem[m_wptr]  = d;
                written[m_wptr] = 1'b1;
                if (l) begin
                    m_len = m_wptr + 1;
                    m_run = 1'b1;
                end else if (m_wptr == DEPTH - 1) begin
                    m_len = DEPTH;
                    m_ovf = 1'b1;
                    m_run = 1'b1;
                end
                m_wptr = (m_wptr + 1) % DEPTH;
            end
        end else if (rl) begin
            m_run  = 1'b0;
            m_wptr = 0;
            m_len  = 0;
            m_ovf  = 1'b0;
            m_ferr = 1'b0;
        end else if (bad_fetch(p)) begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic cycle(input string tag, input logic v, input logic [31:0] d, input logic l,
                         input logic rl, input logic [31:0] p);
        @(posedge clk);
        #1;
        load_valid = v;
        load_data  = d;
        load_last  = l;
        reload     = rl;
        pc         = p;
        expq.push_back(predict(tag, rl, p));
        probe = 1'b1;
        model_step(v, d, l, rl, p);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++)
            cycle(tag, 1'b0, $urandom, 1'b0, 1'b0, $urandom);
    endtask

    task automatic fetch(input string tag, input logic [31:0] p);
        cycle(tag, 1'b0, 32'h0, 1'b0, 1'b0, p);
    endtask

    task automatic pulse_reload(input string tag);
        cycle(tag, 1'b0, 32'h0, 1'b0, 1'b1, $urandom);
    endtask

    task automatic load_random(input string tag, input int n, input bit last, input int maxgap);
        for (int i = 0; i < n; i++) begin
            idle(tag, $urandom_range(0, maxgap));
            cycle(tag, 1'b1, $urandom, last && (i == n - 1), 1'b0, $urandom);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n      = 1'b0;
        probe      = 1'b0;
        load_valid = 1'b0;
        reload     = 1'b0;
        m_run  = 1'b0;
        m_wptr = 0;
        m_len  = 0;
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] pick_pc();
        int unsigned idx;
        logic [31:0] p;
        idx = $urandom_range(0, DEPTH - 1);
        if (!written[idx])
            idx = 0;
        p = idx << 2;
`ifdef IMEM_BOUNDS_CHECK_EN
        case ($urandom_range(0, 3))
            0: p[1:0] = 2'($urandom_range(1, 3));
            1: p = p | ($urandom << (AW + 2));
            default: ;
        endcase
`else
        if ($urandom_range(0, 1) == 1)
            p = p | ($urandom << (AW + 2));
`endif
        return p;
    endfunction

    task automatic cmp(input string name, input string field, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", name, field, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (probe) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: output probed with no expectation queued, got 0, expected 1");
            end else begin
                exp_t e;
                e = expq.pop_front();
                cmp(e.tag, "instr",      instr,             e.instr);
                cmp(e.tag, "core_rst_n", 32'(core_rst_n),   32'(e.crn));
                cmp(e.tag, "load_ready", 32'(load_ready),   32'(e.rdy));
                cmp(e.tag, "prog_len",   32'(prog_len),     e.plen);
                cmp(e.tag, "load_ovf",   32'(load_ovf),     32'(e.ovf));
                cmp(e.tag, "fetch_err",  32'(fetch_err),    32'(e.ferr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] basic_prog [3];

    initial begin
        checks     = 0;
        errors     = 0;
        probe      = 1'b0;
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        reload     = 1'b0;
        pc         = '0;
        for (int i = 0; i < DEPTH; i++)
            written[i] = 1'b0;
        do_reset();

        idle("reset_state", 2);

        basic_prog[0] = 32'h20080005;
        basic_prog[1] = 32'h20090007;
        basic_prog[2] = 32'h01095020;
        for (int i = 0; i < 3; i++)
            cycle("basic_load", 1'b1, basic_prog[i], i == 2, 1'b0, 32'h4);
        fetch("basic_pc4", 32'h4);
        fetch("basic_pc8", 32'h8);
        fetch("basic_pc0", 32'h0);
        fetch("basic_wrap", 32'h10);

`ifdef IMEM_BOUNDS_CHECK_EN
        fetch("bounds_pc10", 32'h10);
        fetch("bounds_sticky", 32'h0);
        fetch("bounds_sticky", 32'h4);
        pulse_reload("bounds_reload");
        for (int i = 0; i < 3; i++)
            cycle("bounds_load", 1'b1, basic_prog[i], i == 2, 1'b0, 32'h0);
        fetch("bounds_pc2", 32'h2);
        fetch("bounds_after", 32'h0);
        fetch("bounds_upper", 32'h8000_0004);
`endif

        pulse_reload("reload_pulse");
        idle("reload_state", 1);
        cycle("reload_load", 1'b1, 32'h00000020, 1'b1, 1'b0, 32'h0);
        fetch("reload_pc0", 32'h0);

        pulse_reload("stall_reload");
        load_random("stall_load", 3, 1'b1, 3);
        fetch("stall_pc0", 32'h0);
        fetch("stall_pc4", 32'h4);
        fetch("stall_pc8", 32'h8);

        pulse_reload("reload_in_load");
        cycle("reload_in_load", 1'b1, 32'hdead_beef, 1'b0, 1'b1, 32'h0);
        cycle("reload_in_load", 1'b1, 32'hcafe_f00d, 1'b1, 1'b0, 32'h0);
        fetch("reload_in_load_pc0", 32'h0);

        pulse_reload("ovf_reload");
        load_random("ovf_load", DEPTH + 1, 1'b0, 1);
        fetch("ovf_pc0", 32'h0);
        fetch("ovf_pcc", 32'hc);

        pulse_reload("midload_reload");
        load_random("midload_load", 2, 1'b0, 1);
        do_reset();
        idle("midload_state", 1);
        load_random("midload_fresh", 2, 1'b1, 1);
        fetch("midload_pc4", 32'h4);

        for (int it = 0; it < 25; it++) begin
            int  n;
            bit  last;
            pulse_reload("rand_reload");
            n    = $urandom_range(1, DEPTH + 1);
            last = (n <= DEPTH) && ($urandom_range(0, 3) != 0);
            load_random("rand_load", n, last, 2);
            for (int k = 0; k < 6; k++)
                fetch("rand_fetch", pick_pc());
        end

        @(posedge clk);
        #1;
        probe = 1'b0;
        @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", expq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
